// File: rtl/led_blink_counter_pkg.sv
// Board-level timing constants shared by the LED blinker and its neighbours.
package led_blink_counter_pkg;

    localparam longint unsigned SYS_CLK_HZ      = 64'd50_000_000;
    // Half-period terminal count for a 1 Hz blink at SYS_CLK_HZ.
    localparam longint unsigned LED_CNT_MAX_1HZ = SYS_CLK_HZ / 64'd2 - 64'd1;

endpackage

// File: rtl/led_blink_counter.sv
// Free-running modulo-(CNT_MAX+1) counter driving a square-wave LED and a
// one-cycle wrap tick; every output comes straight from a flop.
module led_blink_counter
    import led_blink_counter_pkg::*;
#(
    parameter longint unsigned CNT_MAX = LED_CNT_MAX_1HZ
) (
    input  logic sys_clk,
    input  logic sys_rst,
    output logic led_out,
    output logic cnt_flag
);

    localparam int CNT_W = (CNT_MAX < 64'd2) ? 1 : $clog2(CNT_MAX + 64'd1);

    localparam logic [CNT_W-1:0] CNT_TC  = CNT_W'(CNT_MAX);
    localparam logic [CNT_W-1:0] CNT_PRE = CNT_W'(CNT_MAX - 64'd1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    if (CNT_MAX == 64'd0) begin : g_bad_cnt_max
        $error("led_blink_counter: CNT_MAX must be at least 1");
    end

    logic [CNT_W-1:0] cnt;

    // Wrap is an explicit compare so non-power-of-two periods are exact.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            cnt <= '0;
        end else if (cnt == CNT_TC) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_ONE;
        end
    end

    // Registered one step early so the flag lines up with cnt == CNT_MAX.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            cnt_flag <= 1'b0;
        end else begin
            cnt_flag <= (cnt == CNT_PRE);
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            led_out <= 1'b0;
        end else begin
            led_out <= led_out ^ cnt_flag;
        end
    end

endmodule

// File: tb/tb_led_blink_counter.sv
// Randomized run/reset bench for led_blink_counter at CNT_MAX=24 and CNT_MAX=1,
// compared against an edge-count reference model.
module tb_led_blink_counter;

    localparam longint unsigned M_A = 64'd24;
    localparam longint unsigned M_B = 64'd1;

    logic sys_clk;
    logic sys_rst;
    logic led_a, flag_a;
    logic led_b, flag_b;

    int unsigned n_tests;
    int unsigned n_fail;
    longint unsigned n_edges;

    led_blink_counter #(.CNT_MAX(M_A)) dut_a (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .led_out (led_a),
        .cnt_flag(flag_a)
    );

    led_blink_counter #(.CNT_MAX(M_B)) dut_b (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .led_out (led_b),
        .cnt_flag(flag_b)
    );

    initial sys_clk = 1'b0;
    always #10 sys_clk = ~sys_clk;

    // Reference: edges since reset release; everything else is arithmetic on it.
    always @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) n_edges = 0;
        else         n_edges = n_edges + 1;
    end

    function automatic longint unsigned ref_cnt(longint unsigned n, longint unsigned m);
        return n % (m + 1);
    endfunction

    function automatic logic ref_flag(longint unsigned n, longint unsigned m);
        return (n % (m + 1)) == m;
    endfunction

    function automatic logic ref_led(longint unsigned n, longint unsigned m);
        return ((n / (m + 1)) % 2) == 1;
    endfunction

    task automatic chk(input string tag, input longint unsigned act, input longint unsigned exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (edges=%0d, t=%0t)", tag, act, exp, n_edges, $time);
        end
    endtask

    task automatic check_all();
        chk("cnt_a",  64'(dut_a.cnt), ref_cnt(n_edges, M_A));
        chk("flag_a", 64'(flag_a),    64'(ref_flag(n_edges, M_A)));
        chk("led_a",  64'(led_a),     64'(ref_led(n_edges, M_A)));
        chk("cnt_b",  64'(dut_b.cnt), ref_cnt(n_edges, M_B));
        chk("flag_b", 64'(flag_b),    64'(ref_flag(n_edges, M_B)));
        chk("led_b",  64'(led_b),     64'(ref_led(n_edges, M_B)));
    endtask

    task automatic run_cycles(input int n);
        repeat (n) begin
            @(negedge sys_clk);
            check_all();
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_cnt_a"},  64'(dut_a.cnt), 64'd0);
        chk({tag, "_flag_a"}, 64'(flag_a),    64'd0);
        chk({tag, "_led_a"},  64'(led_a),     64'd0);
        chk({tag, "_led_b"},  64'(led_b),     64'd0);
        chk({tag, "_flag_b"}, 64'(flag_b),    64'd0);
    endtask

    int unsigned pulses;
    int unsigned hold;

    initial begin
        n_tests = 0;
        n_fail  = 0;
        n_edges = 0;
        sys_rst = 1'b1;

        // Reset held across ten clock edges.
        repeat (10) begin
            @(negedge sys_clk);
            check_zero("rst_hold");
        end

        // Release, then first toggle after exactly 25 clocks, with pulse counting.
        sys_rst = 1'b0;
        pulses  = 0;
        repeat (250) begin
            @(negedge sys_clk);
            check_all();
            if (flag_a) pulses++;
        end
        chk("pulse_count_250", 64'(pulses), 64'd10);

        // Random run lengths interleaved with asynchronous mid-cycle resets.
        for (int i = 0; i < 24; i++) begin
            run_cycles(int'($urandom_range(3, 120)));
            if (i % 3 == 0) begin
                while (led_a !== 1'b1) begin
                    @(negedge sys_clk);
                    check_all();
                end
            end
            #($urandom_range(1, 8));
            sys_rst = 1'b1;
            #1;
            check_zero("async_rst");
            hold = $urandom_range(1, 3);
            repeat (hold) begin
                @(negedge sys_clk);
                check_zero("rst_held");
            end
            sys_rst = 1'b0;
        end

        run_cycles(60);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
